// File: rtl/lcd_arb_pkg.sv
// rtl/lcd_arb_pkg.sv - shared sizes, fill character and FSM states for the LCD buffer arbiter
package lcd_arb_pkg;

    localparam int LCD_DEPTH  = 32;
    localparam int LCD_ADDR_W = 5;
    localparam int LCD_CHAR_W = 8;
    localparam logic [LCD_CHAR_W-1:0] CHAR_SPACE = 8'h20;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } lcd_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant, search starts one past the last winner
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int LAST_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [LAST_W-1:0]  last,
    output logic [NUM_REQ-1:0] grant
);

    logic [LAST_W-1:0] idx;
    logic              found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        // k == NUM_REQ lands back on last itself, so a lone requester can win again
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = LAST_W'((int'(last) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_buffer_arbiter.sv
// rtl/lcd_buffer_arbiter.sv - 32-char LCD buffer shared by NUM_REQ writers; LCD_ARB_WRITE_COUNT_EN adds write_count
module lcd_buffer_arbiter
    import lcd_arb_pkg::*;
#(
    parameter int                    NUM_REQ    = 2,
    parameter logic [LCD_CHAR_W-1:0] CLEAR_CHAR = CHAR_SPACE
) (
    input  logic                          CLOCK_50,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [LCD_ADDR_W*NUM_REQ-1:0] req_loc,
    input  logic [LCD_CHAR_W*NUM_REQ-1:0] req_char,
    output logic [NUM_REQ-1:0]            grant,
    input  logic                          clear,
    output logic                          busy,
    input  logic [LCD_ADDR_W-1:0]         lcd_index,
    output logic [LCD_CHAR_W-1:0]         lcd_char
`ifdef LCD_ARB_WRITE_COUNT_EN
    ,
    output logic [15:0]                   write_count
`endif
);

    localparam int LAST_W = $clog2(NUM_REQ);

    lcd_arb_state_t          state, state_next;
    logic [LCD_ADDR_W-1:0]   clr_ptr;
    logic [LAST_W-1:0]       last;
    logic [LAST_W-1:0]       gnt_idx;
    logic [NUM_REQ-1:0]      arb_grant;
    logic [LCD_ADDR_W-1:0]   wr_loc;
    logic [LCD_CHAR_W-1:0]   wr_char;
    logic [LCD_CHAR_W-1:0]   buffer [LCD_DEPTH];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .LAST_W  (LAST_W)
    ) u_rr_arbiter (
        .req   (req),
        .last  (last),
        .grant (arb_grant)
    );

    // clear wins over every request in the same cycle; nothing is granted while reset is held
    always_comb begin
        grant = '0;
        if (reset_n && state == ST_IDLE && !clear) begin
            grant = arb_grant;
        end
    end

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_idx = LAST_W'(i);
            end
        end
    end

    assign wr_loc  = req_loc[int'(gnt_idx)*LCD_ADDR_W +: LCD_ADDR_W];
    assign wr_char = req_char[int'(gnt_idx)*LCD_CHAR_W +: LCD_CHAR_W];

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (clear) begin
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (clr_ptr == LCD_ADDR_W'(LCD_DEPTH-1)) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            clr_ptr <= '0;
            last    <= LAST_W'(NUM_REQ-1);
            for (int i = 0; i < LCD_DEPTH; i++) begin
                buffer[i] <= CLEAR_CHAR;
            end
        end else begin
            state <= state_next;
            if (state == ST_CLEAR) begin
                // 31 + 1 wraps to 0, leaving the pointer ready for the next clear
                buffer[clr_ptr] <= CLEAR_CHAR;
                clr_ptr         <= clr_ptr + 1'b1;
            end else if (|grant) begin
                buffer[wr_loc] <= wr_char;
                last           <= gnt_idx;
            end
        end
    end

    assign busy     = (state == ST_CLEAR);
    assign lcd_char = buffer[lcd_index];

`ifdef LCD_ARB_WRITE_COUNT_EN
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            write_count <= '0;
        end else if (state == ST_IDLE && clear) begin
            write_count <= '0;
        end else if (|grant && write_count != 16'hFFFF) begin
            write_count <= write_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lcd_buffer_arbiter.sv
// tb/tb_lcd_buffer_arbiter.sv - directed scenarios plus randomized run against a behavioural buffer model
module tb_lcd_buffer_arbiter;

    localparam int NUM_REQ = 2;

    logic                   CLOCK_50 = 1'b0;
    logic                   reset_n;
    logic [NUM_REQ-1:0]     req;
    logic [5*NUM_REQ-1:0]   req_loc;
    logic [8*NUM_REQ-1:0]   req_char;
    logic [NUM_REQ-1:0]     grant;
    logic                   clear;
    logic                   busy;
    logic [4:0]             lcd_index;
    logic [7:0]             lcd_char;
`ifdef LCD_ARB_WRITE_COUNT_EN
    logic [15:0]            write_count;
`endif

    int checks   = 0;
    int failures = 0;

    lcd_buffer_arbiter #(.NUM_REQ(NUM_REQ), .CLEAR_CHAR(8'h20)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset_n   (reset_n),
        .req       (req),
        .req_loc   (req_loc),
        .req_char  (req_char),
        .grant     (grant),
        .clear     (clear),
        .busy      (busy),
        .lcd_index (lcd_index),
        .lcd_char  (lcd_char)
`ifdef LCD_ARB_WRITE_COUNT_EN
        ,
        .write_count (write_count)
`endif
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // reference model: screen contents, last winner, remaining clear cycles, write tally
    logic [7:0] mbuf [32];
    int         mlast;
    int         mclear_left;
    int         mcount;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
        mlast       = NUM_REQ - 1;
        mclear_left = 0;
        mcount      = 0;
    endfunction

    function automatic logic [NUM_REQ-1:0] model_grant(input logic [NUM_REQ-1:0] r, input logic c);
        logic [NUM_REQ-1:0] g = '0;
        if (mclear_left != 0 || c) return g;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int i = (mlast + k) % NUM_REQ;
            if (r[i]) begin
                g[i] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    function automatic void model_edge(input logic [NUM_REQ-1:0] r, input logic [5*NUM_REQ-1:0] locs,
                                       input logic [8*NUM_REQ-1:0] chars, input logic c);
        logic [NUM_REQ-1:0] g = model_grant(r, c);
        if (mclear_left > 0) begin
            mclear_left--;
        end else if (c) begin
            mclear_left = 32;
            mcount      = 0;
            for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (g[i]) begin
                    mbuf[locs[i*5 +: 5]] = chars[i*8 +: 8];
                    mlast = i;
                    if (mcount < 65535) mcount++;
                end
            end
        end
    endfunction

    task automatic apply_reset();
        reset_n  = 1'b0;
        req      = '0;
        clear    = 1'b0;
        req_loc  = '0;
        req_char = '0;
        lcd_index = '0;
        repeat (2) @(posedge CLOCK_50);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        req = 2'b01; req_loc[4:0] = 5'd3; req_char[7:0] = 8'h33;
        @(posedge CLOCK_50); #1;
        req = '0;
        @(posedge CLOCK_50); #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b want=00", grant); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        for (int i = 0; i < 32; i++) begin
            lcd_index = 5'(i);
            #1;
            checks++;
            if (lcd_char !== 8'h20) begin
                failures++;
                $display("FAIL reset_buf[%0d] got=%h want=20", i, lcd_char);
            end
        end
        @(posedge CLOCK_50); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_single_write();
        apply_reset();
        req = 2'b01; req_loc[4:0] = 5'd5; req_char[7:0] = 8'h41;
        lcd_index = 5'd5;
        #1;
        checks++;
        if (grant !== 2'b01) begin failures++; $display("FAIL single_grant got=%b want=01", grant); end
        checks++;
        if (lcd_char !== 8'h20) begin failures++; $display("FAIL single_before got=%h want=20", lcd_char); end
        @(posedge CLOCK_50); #1;
        req = '0;
        #1;
        checks++;
        if (lcd_char !== 8'h41) begin failures++; $display("FAIL single_after got=%h want=41", lcd_char); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        req = 2'b11;
        for (int i = 0; i < 10; i++) begin
            logic [1:0] want;
            req_loc[4:0]  = 5'(i);      req_char[7:0]  = 8'(8'h60 + i);
            req_loc[9:5]  = 5'(16 + i); req_char[15:8] = 8'(8'h70 + i);
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            checks++;
            if (grant !== want) begin failures++; $display("FAIL rr_cycle%0d got=%b want=%b", i, grant, want); end
            @(posedge CLOCK_50); #1;
        end
        req = '0;
    endtask

    task automatic test_clear_vs_req();
        int cnt;
        apply_reset();
        req = 2'b01; req_loc[4:0] = 5'd2; req_char[7:0] = 8'h77;
        @(posedge CLOCK_50); #1;
        req = 2'b10; req_loc[9:5] = 5'd9; req_char[15:8] = 8'h4B;
        clear = 1'b1;
        #1;
        checks++;
        if (grant !== 2'b00) begin failures++; $display("FAIL clr_prio_grant got=%b want=00", grant); end
        @(posedge CLOCK_50); #1;
        clear = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            // a second clear mid-sequence must not restart it
            clear = (cnt == 5);
            #1;
            if (grant !== 2'b00) begin
                checks++; failures++;
                $display("FAIL clr_busy_grant cycle=%0d got=%b want=00", cnt, grant);
            end
            cnt++;
            @(posedge CLOCK_50); #1;
            clear = 1'b0;
        end
        checks++;
        if (cnt != 32) begin failures++; $display("FAIL clr_busy_len got=%0d want=32", cnt); end
        #1;
        checks++;
        if (grant !== 2'b10) begin failures++; $display("FAIL clr_first_grant got=%b want=10", grant); end
        @(posedge CLOCK_50); #1;
        req = '0;
        for (int i = 0; i < 32; i++) begin
            logic [7:0] want;
            lcd_index = 5'(i);
            want = (i == 9) ? 8'h4B : 8'h20;
            #1;
            checks++;
            if (lcd_char !== want) begin failures++; $display("FAIL clr_buf[%0d] got=%h want=%h", i, lcd_char, want); end
        end
    endtask

    task automatic test_same_location();
        apply_reset();
        lcd_index = 5'd31;
        req = 2'b01; req_loc[4:0] = 5'd31; req_char[7:0] = 8'h58;
        #1;
        checks++;
        if (grant !== 2'b01) begin failures++; $display("FAIL same_g0 got=%b want=01", grant); end
        @(posedge CLOCK_50); #1;
        req = 2'b10; req_loc[9:5] = 5'd31; req_char[15:8] = 8'h59;
        #1;
        checks++;
        if (lcd_char !== 8'h58) begin failures++; $display("FAIL same_mid got=%h want=58", lcd_char); end
        checks++;
        if (grant !== 2'b10) begin failures++; $display("FAIL same_g1 got=%b want=10", grant); end
        @(posedge CLOCK_50); #1;
        req = '0;
        #1;
        checks++;
        if (lcd_char !== 8'h59) begin failures++; $display("FAIL same_final got=%h want=59", lcd_char); end
    endtask

    task automatic test_clear_interrupt();
        apply_reset();
        req = 2'b01; req_loc[4:0] = 5'd30; req_char[7:0] = 8'h41;
        @(posedge CLOCK_50); #1;
        req = '0; clear = 1'b1;
        @(posedge CLOCK_50); #1;
        clear = 1'b0;
        repeat (10) @(posedge CLOCK_50);
        #1;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL intr_busy_before got=%b want=1", busy); end
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL intr_busy_reset got=%b want=0", busy); end
        @(posedge CLOCK_50); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            lcd_index = 5'(i);
            #1;
            checks++;
            if (lcd_char !== 8'h20) begin failures++; $display("FAIL intr_buf[%0d] got=%h want=20", i, lcd_char); end
        end
`ifdef LCD_ARB_WRITE_COUNT_EN
        checks++;
        if (write_count !== 16'd0) begin failures++; $display("FAIL intr_wcount got=%0d want=0", write_count); end
`endif
        req = 2'b10; req_loc[9:5] = 5'd1; req_char[15:8] = 8'h31;
        #1;
        checks++;
        if (grant !== 2'b10) begin failures++; $display("FAIL intr_idle_grant got=%b want=10", grant); end
        @(posedge CLOCK_50); #1;
        req = '0;
    endtask

    task automatic test_random();
        logic [NUM_REQ-1:0] eg;
        logic [NUM_REQ-1:0] prev_g;
        apply_reset();
        prev_g = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req[i] || prev_g[i]) begin
                    req[i]             = 1'($urandom_range(0, 1));
                    req_loc[i*5 +: 5]  = 5'($urandom_range(0, 31));
                    req_char[i*8 +: 8] = 8'($urandom_range(0, 255));
                end
            end
            clear     = ($urandom_range(0, 59) == 0);
            lcd_index = 5'($urandom_range(0, 31));
            #1;
            eg = model_grant(req, clear);
            checks++;
            if (grant !== eg) begin failures++; $display("FAIL rand_grant cyc=%0d got=%b want=%b", cyc, grant, eg); end
            checks++;
            if (busy !== (mclear_left > 0)) begin
                failures++; $display("FAIL rand_busy cyc=%0d got=%b want=%b", cyc, busy, mclear_left > 0);
            end
            if (mclear_left == 0) begin
                checks++;
                if (lcd_char !== mbuf[lcd_index]) begin
                    failures++;
                    $display("FAIL rand_char cyc=%0d idx=%0d got=%h want=%h", cyc, lcd_index, lcd_char, mbuf[lcd_index]);
                end
            end
`ifdef LCD_ARB_WRITE_COUNT_EN
            checks++;
            if (write_count !== 16'(mcount)) begin
                failures++; $display("FAIL rand_wcount cyc=%0d got=%0d want=%0d", cyc, write_count, mcount);
            end
`endif
            prev_g = eg;
            @(posedge CLOCK_50);
            model_edge(req, req_loc, req_char, clear);
            #1;
        end
        req   = '0;
        clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_clear_vs_req();
        test_same_location();
        test_clear_interrupt();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_buffer_arbiter.md
# lcd_buffer_arbiter

- Shares the 16x2 character LCD between several writers.
- Each writer submits (location, character) writes through a req/grant handshake. A round-robin arbiter serializes the writes into a 32-entry display buffer.
- The LCD controller reads the buffer through its `lcd_index`/`lcd_char` pair. It is the buffered replacement for the single-character, single-location source in the LCD demos.
- A clear sequencer refills the buffer with blanks on command.

## Interface
Parameters:
- NUM_REQ, 2, number of writer ports (2..8)
- CLEAR_CHAR, 8'h20, fill value after reset and during clear

Ports:
- CLOCK_50  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- req  input  NUM_REQ  per-writer write request, level
- req_loc  input  5*NUM_REQ  per-writer buffer location; writer i uses bits [5i+4:5i]; 0-15 line 1, 16-31 line 2
- req_char  input  8*NUM_REQ  per-writer character code; writer i uses bits [8i+7:8i]
- grant  output  NUM_REQ  one-hot, one-cycle acknowledge; write commits on this edge
- clear  input  1  single-cycle pulse requesting buffer clear
- busy  output  1  high while the clear sequence runs
- lcd_index  input  5  read address from LCD_Controller
- lcd_char  output  8  buffer[lcd_index], combinational read

## Operation
- Buffer: 32 x 8-bit registers.
- FSM states:
  - IDLE → CLEAR when `clear` is high. `clear` has priority over every `req` in the same cycle.
  - IDLE → IDLE otherwise. While in IDLE, when any `req` is high, one writer is granted and written per cycle.
  - CLEAR: 5-bit counter `clr_ptr` runs 0..31, writing CLEAR_CHAR to `buffer[clr_ptr]` each cycle. When `clr_ptr` reaches 31: write, clear the counter, return to IDLE.
- Arbitration is round-robin:
  - `last` holds the index of the most recently granted writer (reset value NUM_REQ-1).
  - Search order starts at `last`+1 and wraps modulo NUM_REQ.
  - `last` updates only on a grant.
- Handshake:
  - A writer raises `req` and holds `req_loc` and `req_char` stable until it sees `grant`.
  - `req` still high in the cycle after `grant` is a new write.
  - `grant` is never asserted in CLEAR, and never to a writer whose `req` is low.
- Write conflicts:
  - Same-location writes from different writers resolve in grant order; the last granted write persists.
  - A write whose location equals the current `lcd_index` is visible on `lcd_char` from the next cycle.
- `clear` asserted while in CLEAR is ignored; the clear does not restart.
- Reset (including mid-clear):
  - All buffer entries become CLEAR_CHAR.
  - State is IDLE, `clr_ptr`=0, `grant`=0, `busy`=0, `last`=NUM_REQ-1.

## Timing
- Request to grant:
  - 0 cycles: `grant` is combinational from `req`, `last` and state.
  - The buffer updates at the clock edge that ends the grant cycle.
- Sustained throughput: one write per cycle in IDLE. A writer waits at most NUM_REQ-1 cycles when others contend.
- Clear:
  - `busy` is registered. It rises the cycle after `clear` is sampled and stays high exactly 32 cycles.
  - The first cycle with `busy` low again accepts requests.
- `lcd_char` is combinational from `lcd_index`, with zero latency. A new write is visible one cycle after its grant.

## Configuration
- Macro: LCD_ARB_WRITE_COUNT_EN.
- With the macro defined:
  - Extra output `write_count` [15:0] counts granted writes, saturating at 16'hFFFF.
  - `write_count` resets to 0 on reset_n and also to 0 when a clear starts.
  - Intended for HEX display.
- Without the macro: the port and the counter are absent. All other behaviour is identical.

## Structure
- Package `lcd_arb_pkg` holds:
  - LCD_DEPTH=32, LCD_ADDR_W=5, LCD_CHAR_W=8, CHAR_SPACE=8'h20
  - FSM state enum {ST_IDLE, ST_CLEAR}
- Sub-module `rr_arbiter`:
  - Parameter NUM_REQ; inputs `req`, `last`; output one-hot `grant`. Purely combinational.
  - `last` is held in the parent.
- The parent holds the buffer, the FSM, `clr_ptr` and the optional counter.

## Test plan
- Reset check: assert reset_n low mid-run, sweep `lcd_index` 0..31 → `lcd_char`=8'h20 everywhere; `grant`=0, `busy`=0.
- Single write: writer0 req, loc=5, char=8'h41 → `grant`=2'b01 the same cycle; next cycle `lcd_index`=5 returns 8'h41.
- Contention: both writers hold req continuously from reset → grants alternate 2'b01, 2'b10, 2'b01… with no gaps.
- Clear vs request: pulse `clear` with writer1 req in the same cycle → no grant, `busy` high for 32 cycles, writer1 granted on the first cycle `busy` is low; buffer all 8'h20 except writer1's entry.
- Same-location conflict: writer0 writes loc=31 char 8'h58, then writer1 writes loc=31 char 8'h59 → `lcd_char` at index 31 reads 8'h59.
- Clear interruption: assert reset_n low mid-clear at `clr_ptr`=10, then release → all entries 8'h20, state IDLE; with LCD_ARB_WRITE_COUNT_EN, `write_count`=0.
